stack_cpu_controller: RTL and testbench

- Multicycle control/datapath core for the 8-bit stack processor; the initiator on the 32x8 unified instruction/data memory interface.
- Fetches instructions, decodes them and executes them against an internal LIFO operand stack.
- Drives address, readData, writeData and dataIn; consumes DorI.
- Instruction format: opcode[7:5], operand address[4:0].
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ.

---
 rtl/stack_cpu_pkg.sv | 46 ++++
 rtl/stack_cpu_stack.sv | 65 ++++++
 rtl/stack_cpu_controller.sv | 189 ++++++++++++++++++
 tb/tb_stack_cpu_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_cpu_pkg.sv
// -----------------------------------------------------------------------------
// stack_cpu_pkg
// Shared definitions for the 8-bit stack processor core:
//   - ADDR_W / DATA_W   memory address and data widths
//   - OP_ADD .. OP_JZ   opcode values found in instruction bits [7:5]
//   - state_t           controller state encoding (ST_HALT is only entered
//                       when STACK_CPU_BOUNDS_CHECK_EN is defined)
//   - alu()             result of the stack-register ALU instructions
// -----------------------------------------------------------------------------
package stack_cpu_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_NOT  = 3'b011;
   localparam logic [2:0] OP_PUSH = 3'b100;
   localparam logic [2:0] OP_POP  = 3'b101;
   localparam logic [2:0] OP_JMP  = 3'b110;
   localparam logic [2:0] OP_JZ   = 3'b111;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   // Arithmetic wraps mod 256 by truncation to DATA_W bits.
   // SUB is TOS minus NOS.
   function automatic logic [DATA_W-1:0] alu(input logic [2:0]        op,
                                             input logic [DATA_W-1:0] t,
                                             input logic [DATA_W-1:0] n);
      logic [DATA_W-1:0] r;
      case (op)
         OP_ADD:  r = t + n;
         OP_SUB:  r = t - n;
         OP_AND:  r = t & n;
         default: r = ~t;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/stack_cpu_stack.sv
// -----------------------------------------------------------------------------
// stack_cpu_stack
// DEPTH x 8 LIFO register file holding the operand stack.
//   clk, rst   clock, synchronous active-high reset (clears count and contents)
//   push       write wdata at stack[sp], sp+1
//   pop        sp-1
//   wr_top     write wdata into the entry that is top after this cycle's pop
//              (pop+wr_top = binary op result, wr_top alone = replace top)
//   wdata      write data
//   tos, nos   combinational top / next-on-stack (tos is 0 when empty)
//   sp         number of valid entries; wraps in SPW bits, index wraps mod DEPTH
// -----------------------------------------------------------------------------
module stack_cpu_stack
   import stack_cpu_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int SPW   = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              wr_top,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] tos,
   output logic [DATA_W-1:0] nos,
   output logic [SPW-1:0]    sp
);

   localparam int IW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IW-1:0]     sp_lo;
   logic [IW-1:0]     tos_idx;
   logic [IW-1:0]     nos_idx;
   logic [IW-1:0]     wr_idx;

   // Index arithmetic is done in IW bits so it wraps mod DEPTH.
   assign sp_lo   = sp[IW-1:0];
   assign tos_idx = sp_lo - IW'(1);
   assign nos_idx = sp_lo - IW'(2);
   assign wr_idx  = push ? sp_lo : (pop ? nos_idx : tos_idx);

   assign tos = (sp == '0) ? '0 : mem[tos_idx];
   assign nos = mem[nos_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         sp <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            sp <= sp + SPW'(1);
         end else if (pop) begin
            sp <= sp - SPW'(1);
         end
         if (push || wr_top) begin
            mem[wr_idx] <= wdata;
         end
      end
   end

endmodule

// File: rtl/stack_cpu_controller.sv
// -----------------------------------------------------------------------------
// stack_cpu_controller
// Multicycle control/datapath core of the 8-bit stack processor. Each
// instruction runs FETCH -> DECODE -> EXEC (3 cycles) against a 32x8 unified
// instruction/data memory and an internal operand stack.
//   clk, rst    clock, synchronous active-high reset
//   address     memory address            (Moore output)
//   readData    memory read enable        (Moore output)
//   writeData   memory write enable, memory writes at posedge
//   dataIn      memory write data (TOS during POP)
//   DorI        memory read data, combinational in address/readData
//   pc          program counter
//   tos         top of stack, 0 when empty
//   sp          number of valid stack entries
//   err         sticky stack-bounds error
// Optional feature macro: STACK_CPU_BOUNDS_CHECK_EN
//   defined   : stack over/underflow sets err and parks the FSM in ST_HALT
//   undefined : err tied 0, pointers wrap and the instruction just executes
// -----------------------------------------------------------------------------
module stack_cpu_controller
   import stack_cpu_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int SPW   = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] address,
   output logic              readData,
   output logic              writeData,
   output logic [DATA_W-1:0] dataIn,
   input  logic [DATA_W-1:0] DorI,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] tos,
   output logic [SPW-1:0]    sp,
   output logic              err
);

   state_t            state;
   state_t            state_next;
   logic [DATA_W-1:0] ir;
   logic [ADDR_W-1:0] pc_next;
   logic              ir_load;
   logic [2:0]        opcode;
   logic [ADDR_W-1:0] opaddr;
   logic              viol;
   logic              push;
   logic              pop;
   logic              wr_top;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] nos;
`ifdef STACK_CPU_BOUNDS_CHECK_EN
   logic              err_q;
   logic              err_set;
`endif

   assign opcode = ir[7:5];
   assign opaddr = ir[4:0];

   stack_cpu_stack #(
      .DEPTH (DEPTH),
      .SPW   (SPW)
   ) u_stack (
      .clk    (clk),
      .rst    (rst),
      .push   (push),
      .pop    (pop),
      .wr_top (wr_top),
      .wdata  (wdata),
      .tos    (tos),
      .nos    (nos),
      .sp     (sp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_FETCH;
         pc    <= '0;
         ir    <= '0;
`ifdef STACK_CPU_BOUNDS_CHECK_EN
         err_q <= 1'b0;
`endif
      end else begin
         state <= state_next;
         pc    <= pc_next;
         if (ir_load) begin
            ir <= DorI;
         end
`ifdef STACK_CPU_BOUNDS_CHECK_EN
         err_q <= err_q | err_set;
`endif
      end
   end

`ifdef STACK_CPU_BOUNDS_CHECK_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_next = state;
      pc_next    = pc;
      ir_load    = 1'b0;
      address    = pc;
      readData   = 1'b0;
      writeData  = 1'b0;
      dataIn     = '0;
      push       = 1'b0;
      pop        = 1'b0;
      wr_top     = 1'b0;
      wdata      = DorI;
      viol       = 1'b0;
`ifdef STACK_CPU_BOUNDS_CHECK_EN
      err_set    = 1'b0;
      case (opcode)
         OP_PUSH:                viol = (sp == SPW'(DEPTH));
         OP_POP, OP_NOT, OP_JZ:  viol = (sp == '0);
         OP_ADD, OP_SUB, OP_AND: viol = (sp < SPW'(2));
         default:                viol = 1'b0;
      endcase
`endif

      case (state)
         ST_FETCH: begin
            address    = pc;
            readData   = 1'b1;
            ir_load    = 1'b1;
            pc_next    = pc + ADDR_W'(1);
            state_next = ST_DECODE;
         end
         ST_DECODE: begin
            address    = opaddr;
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            address    = opaddr;
            state_next = ST_FETCH;
            // A violating instruction leaves stack, sp and pc untouched.
            case (opcode)
               OP_PUSH: begin
                  readData = 1'b1;
                  push     = ~viol;
               end
               OP_POP: begin
                  writeData = ~viol;
                  dataIn    = tos;
                  pop       = ~viol;
               end
               OP_ADD, OP_SUB, OP_AND: begin
                  pop    = ~viol;
                  wr_top = ~viol;
                  wdata  = alu(opcode, tos, nos);
               end
               OP_NOT: begin
                  wr_top = ~viol;
                  wdata  = alu(opcode, tos, nos);
               end
               OP_JMP: begin
                  pc_next = opaddr;
               end
               OP_JZ: begin
                  if (!viol && tos == '0) begin
                     pc_next = opaddr;
                  end
               end
               default: begin
               end
            endcase
`ifdef STACK_CPU_BOUNDS_CHECK_EN
            if (viol) begin
               err_set    = 1'b1;
               state_next = ST_HALT;
            end
`endif
         end
         default: begin
            // ST_HALT: memory interface quiet, only rst leaves.
            address = '0;
`ifdef STACK_CPU_BOUNDS_CHECK_EN
            state_next = ST_HALT;
`else
            state_next = ST_FETCH;
`endif
         end
      endcase
   end

endmodule

// File: tb/tb_stack_cpu_controller.sv
module tb_stack_cpu_controller;
   localparam int DEPTH = 8;
   localparam int SPW   = $clog2(DEPTH) + 1;

   logic            clk;
   logic            rst;
   logic [4:0]      address;
   logic            readData;
   logic            writeData;
   logic [7:0]      dataIn;
   logic [7:0]      DorI;
   logic [4:0]      pc;
   logic [7:0]      tos;
   logic [SPW-1:0]  sp;
   logic            err;

   stack_cpu_controller #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .address   (address),
      .readData  (readData),
      .writeData (writeData),
      .dataIn    (dataIn),
      .DorI      (DorI),
      .pc        (pc),
      .tos       (tos),
      .sp        (sp),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory fixture: combinational read, write at posedge, image load port.
   logic [7:0] fmem [32];
   logic [7:0] img  [32];
   logic       load_en;

   assign DorI = fmem[address];

   always @(posedge clk) begin
      if (writeData) fmem[address] <= dataIn;
      else if (load_en) begin
         for (int i = 0; i < 32; i++) fmem[i] <= img[i];
      end
   end

   // Scoreboard queues filled by the reference model.
   typedef struct { int pc; int sp; logic [7:0] tos; } st_t;
   typedef struct { int addr; logic [7:0] data; } wr_t;
   st_t exp_st[$];
   wr_t exp_wr[$];
   logic [7:0] m [32];

   int  n_vec = 0;
   int  n_err = 0;
   bit  mon_on = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ISA-level reference: run k instructions from the loaded image.
   task automatic model_run(input int k, output bit bad);
      logic [7:0] stk[$];
      logic [7:0] ins, t, n;
      int mpc, a;
      logic [2:0] op;
      bad = 0;
      exp_st.delete();
      exp_wr.delete();
      for (int i = 0; i < 32; i++) m[i] = img[i];
      mpc = 0;
      for (int s = 0; s < k && !bad; s++) begin
         exp_st.push_back('{mpc, stk.size(), (stk.size() > 0) ? stk[$] : 8'h00});
         ins = m[mpc];
         mpc = (mpc + 1) % 32;
         op  = ins[7:5];
         a   = int'(ins[4:0]);
         case (op)
            3'd4: if (stk.size() == DEPTH) bad = 1; else stk.push_back(m[a]);
            3'd5: if (stk.size() == 0) bad = 1;
                  else begin exp_wr.push_back('{a, stk[$]}); m[a] = stk.pop_back(); end
            3'd0, 3'd1, 3'd2:
                  if (stk.size() < 2) bad = 1;
                  else begin
                     t = stk.pop_back();
                     n = stk.pop_back();
                     stk.push_back(op == 3'd0 ? t + n : op == 3'd1 ? t - n : t & n);
                  end
            3'd3: if (stk.size() == 0) bad = 1; else stk[stk.size()-1] = ~stk[stk.size()-1];
            3'd6: mpc = a;
            default: if (stk.size() == 0) bad = 1; else if (stk[$] == 8'h00) mpc = a;
         endcase
      end
   endtask

   // Monitor: instruction boundary every 3rd cycle, and every memory write.
   int cyc = 0;
   always @(negedge clk) begin
      st_t e;
      wr_t w;
      if (!mon_on) cyc = 0;
      else begin
         if (cyc % 3 == 0) begin
            if (exp_st.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL fetch_state: unexpected boundary at pc %0d", pc);
            end else begin
               e = exp_st.pop_front();
               chk("fetch_state", {39'd0, pc, 4'(sp), tos, err, address, readData, writeData},
                   {39'd0, 5'(e.pc), 4'(e.sp), e.tos, 1'b0, 5'(e.pc), 1'b1, 1'b0});
            end
         end
         if (writeData) begin
            if (exp_wr.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL mem_write: unexpected write addr %0d data %h", address, dataIn);
            end else begin
               w = exp_wr.pop_front();
               chk("mem_write", {49'd0, address, dataIn, readData},
                   {49'd0, 5'(w.addr), w.data, 1'b0});
            end
         end
         cyc++;
      end
   end

   task automatic load_img();
      rst = 1'b1;
      load_en = 1'b1;
      @(posedge clk); #2;
      @(posedge clk); #2;
      load_en = 1'b0;
   endtask

   task automatic run_prog(input int k);
      bit bad;
      load_img();
      model_run(k, bad);
      chk("reset_state", {30'd0, pc, 4'(sp), tos, err, address, readData, writeData, dataIn},
          {30'd0, 5'd0, 4'd0, 8'd0, 1'b0, 5'd0, 1'b1, 1'b0, 8'd0});
      rst = 1'b0;
      mon_on = 1;
      repeat (3 * k) @(posedge clk);
      #2;
      mon_on = 0;
      chk("writes_pending", 64'(exp_wr.size()), 64'd0);
      for (int i = 0; i < 32; i++) chk($sformatf("mem[%0d]", i), 64'(fmem[i]), 64'(m[i]));
   endtask

   task automatic clear_img();
      for (int i = 0; i < 32; i++) img[i] = 8'h00;
   endtask

   // Random program whose every path keeps the stack within bounds:
   // jumps only target instructions entered with the same stack depth.
   task automatic gen_random();
      int d[20];
      int depth, op, a, j;
      bit ok;
      for (int i = 20; i < 32; i++) img[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      depth = 0;
      for (int i = 0; i < 20; i++) begin
         d[i] = depth;
         ok = 0;
         op = 6;
         while (!ok) begin
            op = (i == 19) ? 6 : $urandom_range(0, 7);
            case (op)
               4:       ok = depth < DEPTH;
               5, 3, 7: ok = depth >= 1;
               0, 1, 2: ok = depth >= 2;
               default: ok = 1;
            endcase
         end
         a = $urandom_range(0, 31);
         if (op == 4 || op == 5) a = $urandom_range(20, 31);
         if (op == 6 || op == 7) begin
            j = $urandom_range(0, i);
            while (d[j] != depth) j = $urandom_range(0, i);
            a = j;
         end
         if (op == 4) depth++;
         if (op == 5 || op <= 2) depth--;
         img[i] = {3'(op), 5'(a)};
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      load_en = 1'b0;
      clear_img();
      for (int i = 0; i < 32; i++) fmem[i] = 8'h00;

      // Sum of five operands
      clear_img();
      for (int i = 0; i < 5; i++) img[i] = 8'h80 | 8'(25 + i);
      for (int i = 5; i < 9; i++) img[i] = 8'h00;
      img[9] = 8'hBE;
      img[25] = 8'd9; img[26] = 8'd7; img[27] = 8'd5; img[28] = 8'd3; img[29] = 8'd1;
      run_prog(10);
      chk("sum_mem30", 64'(fmem[30]), 64'h19);
      chk("sum_end_pc_sp", {55'd0, pc, 4'(sp)}, {55'd0, 5'd10, 4'd0});

      // JMP / JZ not taken then taken
      clear_img();
      img[0] = 8'h94; img[1] = 8'h94; img[2] = 8'h00; img[3] = 8'hC7;
      img[7] = 8'hEC; img[8] = 8'h95; img[9] = 8'h20; img[10] = 8'hEF;
      img[20] = 8'd8; img[21] = 8'd16;
      run_prog(8);
      chk("jz_end", {47'd0, pc, tos, 4'(sp)}, {47'd0, 5'd15, 8'h00, 4'd1});

      // Logic ops: ~(0xAA & 0x66) = 0xDD
      clear_img();
      img[0] = 8'h94; img[1] = 8'h95; img[2] = 8'h40; img[3] = 8'h60; img[4] = 8'hBF;
      img[20] = 8'hAA; img[21] = 8'h66;
      run_prog(5);
      chk("logic_mem31", 64'(fmem[31]), 64'hDD);

      // PC wrap 31 -> 0
      clear_img();
      img[0] = 8'hDF; img[31] = 8'h94; img[20] = 8'h33;
      run_prog(4);
      chk("wrap_end", {55'd0, pc, 4'(sp)}, {55'd0, 5'd0, 4'd2});

      // Reset during POP EXEC: the write still lands
      clear_img();
      img[0] = 8'h94; img[1] = 8'hB5; img[20] = 8'h5A;
      load_img();
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("pop_exec_bus", {49'd0, writeData, readData, address, dataIn}, {49'd0, 1'b1, 1'b0, 5'd21, 8'h5A});
      rst = 1'b1;
      @(posedge clk); #2;
      chk("rst_pop_mem21", 64'(fmem[21]), 64'h5A);
      chk("rst_pop_state", {44'd0, pc, 4'(sp), tos, err, address, readData},
          {44'd0, 5'd0, 4'd0, 8'd0, 1'b0, 5'd0, 1'b1});

      // POP on an empty stack
      clear_img();
      img[0] = 8'hB5; img[1] = 8'h94; img[20] = 8'h11; img[21] = 8'h77;
      load_img();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
`ifdef STACK_CPU_BOUNDS_CHECK_EN
      chk("bnd_exec_we", 64'(writeData), 64'd0);
      @(posedge clk); #2;
      chk("bnd_halt", {45'd0, err, readData, writeData, address, dataIn, pc},
          {45'd0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 5'd1});
      repeat (3) @(posedge clk);
      #2;
      chk("bnd_halt_stay", {45'd0, err, readData, writeData, address, dataIn, pc},
          {45'd0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 5'd1});
      chk("bnd_no_write", 64'(fmem[21]), 64'h77);
`else
      chk("bnd_exec_bus", {49'd0, writeData, readData, address, dataIn}, {49'd0, 1'b1, 1'b0, 5'd21, 8'h00});
      @(posedge clk); #2;
      chk("bnd_wrap", {54'd0, err, pc, 4'(sp)}, {54'd0, 1'b0, 5'd1, 4'hF});
      repeat (3) @(posedge clk);
      #2;
      chk("bnd_continue", {58'd0, err, pc}, {58'd0, 1'b0, 5'd2});
`endif
      rst = 1'b1;
      @(posedge clk); #2;
      chk("bnd_reset", {58'd0, err, pc}, {58'd0, 1'b0, 5'd0});

      // Randomized programs
      for (int r = 0; r < 15; r++) begin
         clear_img();
         gen_random();
         run_prog(30);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
